// File: rtl/ecg_acq_if.sv
// Handshake and data bundle between the ECG acquisition sequencer, the ADC and the filter chain.
// The slave modport is the sequencer's view; the master modport is the surrounding board/ADC side.
interface ecg_acq_if #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 12
);
  logic              switch;
  logic [DIV_W-1:0]  div_val;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;
  logic              adc_start;
  logic              clk_d_en;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              busy;
  logic              timeout_err;
  logic              overrun_err;

  modport slave (
    input  switch, div_val, adc_done, adc_data,
    output adc_start, clk_d_en, sample_data, sample_valid, busy, timeout_err, overrun_err
  );

  modport master (
    output switch, div_val, adc_done, adc_data,
    input  adc_start, clk_d_en, sample_data, sample_valid, busy, timeout_err, overrun_err
  );
endinterface

// File: rtl/ecg_acq_ctrl.sv
// ECG acquisition sequencer: programmable sample tick, ADC start/done handshake with timeout, sample publish.
// Define ACQ_AVG2_EN to publish the average of each pair of captures instead of every raw capture.
module ecg_acq_ctrl #(
  parameter int DIV_W   = 16,
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      rst,
  ecg_acq_if.slave  acq
);

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARM, CONV} state_t;

  state_t            state, state_nxt;
  logic              switch_p0, switch_p1, switch_p2;
  logic              switch_s, switch_rise;
  logic [DIV_W-1:0]  cnt, div_eff;
  logic              tick;
  logic [TO_W-1:0]   tcnt;
  logic              start_nxt, capture, tmo_hit, ovr_hit, tcnt_clr, tcnt_inc;
  logic              adc_start_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              tmo_err, ovr_err;

  // Truncating pair average; the extra sum bit keeps the carry before the shift.
  function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_W:1];
  endfunction

  // Stage p0..p1: switch synchronizer, p2 holds the previous synced value for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      switch_p0 <= 1'b0;
      switch_p1 <= 1'b0;
      switch_p2 <= 1'b0;
    end else begin
      switch_p0 <= acq.switch;
      switch_p1 <= switch_p0;
      switch_p2 <= switch_p1;
    end
  end

  assign switch_s    = switch_p1;
  assign switch_rise = switch_p1 & ~switch_p2;

  // A divide value of 0 behaves like 1; a counter past a newly lowered value wraps before ticking.
  assign div_eff = (acq.div_val == '0) ? DIV_W'(1) : acq.div_val;
  assign tick    = switch_s && (cnt == div_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt <= '0;
    else if (!switch_s) cnt <= '0;
    else if (tick)      cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    capture   = 1'b0;
    tmo_hit   = 1'b0;
    ovr_hit   = 1'b0;
    tcnt_clr  = 1'b0;
    tcnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (switch_s) state_nxt = ARM;
      end
      ARM: begin
        if (!switch_s) begin
          state_nxt = IDLE;
        end else if (tick) begin
          start_nxt = 1'b1;
          tcnt_clr  = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        ovr_hit = tick;
        // done has priority over the terminal timeout count
        if (acq.adc_done) begin
          capture   = 1'b1;
          state_nxt = ARM;
        end else if (tcnt == TO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ARM;
        end else begin
          tcnt_inc  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           tcnt <= '0;
    else if (tcnt_clr) tcnt <= '0;
    else if (tcnt_inc) tcnt <= tcnt + 1'b1;
  end

`ifdef ACQ_AVG2_EN
  logic              pair_phase;
  logic [DATA_W-1:0] pair_p0;

  always_ff @(posedge clk) begin
    if (capture && !pair_phase) pair_p0 <= acq.adc_data;
  end
`endif

  // Stage p0: registered start pulse, published sample and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_start_p0 <= 1'b0;
      vld_p0       <= 1'b0;
      data_p0      <= '0;
      tmo_err      <= 1'b0;
      ovr_err      <= 1'b0;
`ifdef ACQ_AVG2_EN
      pair_phase   <= 1'b0;
`endif
    end else begin
      adc_start_p0 <= start_nxt;
      tmo_err      <= tmo_hit | (tmo_err & ~switch_rise);
      ovr_err      <= ovr_hit | (ovr_err & ~switch_rise);
`ifdef ACQ_AVG2_EN
      vld_p0 <= capture & pair_phase;
      if (capture && pair_phase) data_p0 <= avg2(pair_p0, acq.adc_data);
      if (tmo_hit || (state_nxt == IDLE && state != IDLE)) pair_phase <= 1'b0;
      else if (capture)                                    pair_phase <= ~pair_phase;
`else
      vld_p0 <= capture;
      if (capture) data_p0 <= acq.adc_data;
`endif
    end
  end

  assign acq.adc_start    = adc_start_p0;
  assign acq.clk_d_en     = tick;
  assign acq.sample_data  = data_p0;
  assign acq.sample_valid = vld_p0;
  assign acq.busy         = (state == CONV);
  assign acq.timeout_err  = tmo_err;
  assign acq.overrun_err  = ovr_err;

endmodule
